// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: counter encodings,
// PC increment and the branch-predictor entry layout.
package fetch_pkg;

    // 2-bit saturating branch counter
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam logic [31:0] PC_STEP = 32'd4;

    // Tags are stored in a field wide enough for the smallest index width;
    // unused upper bits stay zero.
    localparam int TAG_FIELD_W = 30;

    typedef struct packed {
        logic                   valid;
        logic [TAG_FIELD_W-1:0] tag;
        logic [31:0]            target;
        ctr_t                   ctr;
    } bht_entry_t;

    // Saturating counter step towards the resolved outcome
    function automatic ctr_t ctr_step(input ctr_t cur, input logic taken);
        ctr_t res;
        res = cur;
        if (taken) begin
            case (cur)
                SNT:     res = WNT;
                WNT:     res = WT;
                default: res = ST;
            endcase
        end else begin
            case (cur)
                ST:      res = WT;
                WT:      res = WNT;
                default: res = SNT;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped branch history table plus branch target buffer.
// Lookup is purely combinational; updates are written at the clock edge,
// so a same-cycle lookup of the entry being updated sees the old contents.
module branch_predictor
    import fetch_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] lookup_word,
    output logic        hit_take,
    output logic [31:0] hit_target,
    input  logic        update_en,
    input  logic [29:0] update_word,
    input  logic        update_taken,
    input  logic [31:0] update_target
);

    localparam int ENTRIES = 1 << IDX_W;

    bht_entry_t entries [ENTRIES];

    logic [IDX_W-1:0]       lookup_idx;
    logic [TAG_FIELD_W-1:0] lookup_tag;
    logic [IDX_W-1:0]       update_idx;
    logic [TAG_FIELD_W-1:0] update_tag;
    bht_entry_t             lookup_entry;

    // Split word addresses into index and zero-extended tag
    always_comb begin
        lookup_idx = lookup_word[IDX_W-1:0];
        lookup_tag = {{IDX_W{1'b0}}, lookup_word[29:IDX_W]};
        update_idx = update_word[IDX_W-1:0];
        update_tag = {{IDX_W{1'b0}}, update_word[29:IDX_W]};
    end

    // Combinational prediction for the word currently being fetched
    always_comb begin
        lookup_entry = entries[lookup_idx];
        hit_take     = lookup_entry.valid &&
                       (lookup_entry.tag == lookup_tag) &&
                       (lookup_entry.ctr inside {WT, ST});
        hit_target   = lookup_entry.target;
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            // Per-entry state: taken outcomes (re)allocate the entry,
            // not-taken outcomes only age the counter.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    entries[gi].valid  <= 1'b0;
                    entries[gi].tag    <= '0;
                    entries[gi].target <= '0;
                    entries[gi].ctr    <= WNT;
                end else if (update_en && (update_idx == IDX_W'(gi))) begin
                    entries[gi].ctr <= ctr_step(entries[gi].ctr, update_taken);
                    if (update_taken) begin
                        entries[gi].valid  <= 1'b1;
                        entries[gi].tag    <= update_tag;
                        entries[gi].target <= update_target;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// address and redirects on EX mispredicts, ID jumps and predicted-taken
// branches.
module if_fetch_stage
    import fetch_pkg::*;
#(
    parameter int          BHT_IDX_W = 4,
    parameter logic [31:0] RESET_PC  = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_stall,
    input  logic        ID_branch,
    input  logic [31:0] ID_jump_target,
    input  logic        EX_branch,
    input  logic        EX_zero,
    input  logic        EX_pred_take,
    input  logic [31:0] EX_pc,
    input  logic [31:0] EX_branch_target,
    output logic [31:0] inst_mem_read_addr,
    output logic        IF_take
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic        mispredict;
    logic        update_en;
    logic [29:0] update_word;
    logic        pred_take;
    logic [31:0] pred_target;

    // Resolution signals; EX_pc is branch+4, so the branch word is one less.
    // A stalled EX stage must not train the predictor, even on a mispredict.
    always_comb begin
        mispredict  = EX_branch && (EX_zero != EX_pred_take);
        update_en   = EX_branch && !EX_stall;
        update_word = EX_pc[31:2] - 30'd1;
    end

    branch_predictor #(
        .IDX_W (BHT_IDX_W)
    ) u_predictor (
        .clk           (clk),
        .reset         (reset),
        .lookup_word   (pc_reg[31:2]),
        .hit_take      (pred_take),
        .hit_target    (pred_target),
        .update_en     (update_en),
        .update_word   (update_word),
        .update_taken  (EX_zero),
        .update_target (EX_branch_target)
    );

    // Next-PC priority: mispredict > stall > ID jump > prediction > +4
    always_comb begin
        pc_next = pc_reg + PC_STEP;
        if (mispredict) begin
            pc_next = EX_zero ? EX_branch_target : EX_pc;
        end else if (EX_stall) begin
            pc_next = pc_reg;
        end else if (ID_branch) begin
            pc_next = ID_jump_target;
        end else if (pred_take) begin
            pc_next = pred_target;
        end
    end

    // Program counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign inst_mem_read_addr = pc_reg;
    assign IF_take            = pred_take;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a directed vector table, short
// hand-written corner sequences, then random traffic against a model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        EX_stall = 1'b0;
    logic        ID_branch = 1'b0;
    logic [31:0] ID_jump_target = '0;
    logic        EX_branch = 1'b0;
    logic        EX_zero = 1'b0;
    logic        EX_pred_take = 1'b0;
    logic [31:0] EX_pc = '0;
    logic [31:0] EX_branch_target = '0;
    logic [31:0] inst_mem_read_addr;
    logic        IF_take;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    if_fetch_stage #(
        .BHT_IDX_W (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .EX_stall           (EX_stall),
        .ID_branch          (ID_branch),
        .ID_jump_target     (ID_jump_target),
        .EX_branch          (EX_branch),
        .EX_zero            (EX_zero),
        .EX_pred_take       (EX_pred_take),
        .EX_pc              (EX_pc),
        .EX_branch_target   (EX_branch_target),
        .inst_mem_read_addr (inst_mem_read_addr),
        .IF_take            (IF_take)
    );

    typedef struct {
        logic        stall;
        logic        idb;
        logic [31:0] idt;
        logic        exb;
        logic        exz;
        logic        expt;
        logic [31:0] expc;
        logic [31:0] ext;
        logic [31:0] exp_pc;
        logic        exp_take;
    } vec_t;

    vec_t vt [18];

    // ---------------- reference model (16 entries) ----------------
    logic        m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_pc;

    function automatic logic m_take(input logic [31:0] a);
        int i;
        i = int'((a >> 2) % 32'd16);
        return m_valid[i] && (m_tag[i] == (a >> 6)) && (m_ctr[i] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
            m_ctr[i]   = 1;
        end
        m_pc = 32'h0;
    endtask

    task automatic m_step();
        logic [31:0] a;
        int          i;
        int          hi;
        logic        mis;
        logic        tk;
        logic [31:0] np;
        hi  = int'((m_pc >> 2) % 32'd16);
        tk  = m_take(m_pc);
        mis = EX_branch && (EX_zero != EX_pred_take);
        if (mis)            np = EX_zero ? EX_branch_target : EX_pc;
        else if (EX_stall)  np = m_pc;
        else if (ID_branch) np = ID_jump_target;
        else if (tk)        np = m_tgt[hi];
        else                np = m_pc + 32'd4;
        if (EX_branch && !EX_stall) begin
            a = EX_pc - 32'd4;
            i = int'((a >> 2) % 32'd16);
            if (EX_zero) begin
                m_ctr[i]   = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
                m_valid[i] = 1'b1;
                m_tag[i]   = a >> 6;
                m_tgt[i]   = EX_branch_target;
            end else begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end
        m_pc = np;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic ib, input logic [31:0] it,
                         input logic eb, input logic ez, input logic ep,
                         input logic [31:0] ec, input logic [31:0] et);
        EX_stall = st; ID_branch = ib; ID_jump_target = it;
        EX_branch = eb; EX_zero = ez; EX_pred_take = ep;
        EX_pc = ec; EX_branch_target = et;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic st, input logic ib, input logic [31:0] it,
                                input logic eb, input logic ez, input logic ep,
                                input logic [31:0] ec, input logic [31:0] et,
                                input logic [31:0] xp, input logic xt);
        vec_t v;
        v.stall = st; v.idb = ib; v.idt = it; v.exb = eb; v.exz = ez; v.expt = ep;
        v.expc = ec; v.ext = et; v.exp_pc = xp; v.exp_take = xt;
        return v;
    endfunction

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #7;
        reset = 1'b0;
        m_reset();
        #1;
    endtask

    initial begin
        // Directed sequence from reset; columns: stall, idb, idt, exb, exz, expt, expc, ext -> pc, take
        vt[0]  = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h4,   0);
        vt[1]  = mk(0, 1, 32'h10,  0, 0, 0, 32'h0,  32'h0,  32'h10,  0);
        vt[2]  = mk(1, 1, 32'h100, 0, 0, 0, 32'h0,  32'h0,  32'h10,  0);
        vt[3]  = mk(0, 1, 32'h100, 0, 0, 0, 32'h0,  32'h0,  32'h100, 0);
        vt[4]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h24, 32'h80, 32'h80,  0);
        vt[5]  = mk(0, 0, 32'h0,   1, 1, 0, 32'h24, 32'h80, 32'h80,  0);
        vt[6]  = mk(0, 1, 32'h20,  0, 0, 0, 32'h0,  32'h0,  32'h20,  1);
        vt[7]  = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h80,  0);
        vt[8]  = mk(0, 0, 32'h0,   1, 0, 1, 32'h24, 32'h80, 32'h24,  0);
        vt[9]  = mk(0, 1, 32'h20,  0, 0, 0, 32'h0,  32'h0,  32'h20,  1);
        vt[10] = mk(1, 1, 32'h300, 1, 1, 0, 32'h24, 32'h90, 32'h90,  0);
        vt[11] = mk(0, 1, 32'h20,  0, 0, 0, 32'h0,  32'h0,  32'h20,  1);
        vt[12] = mk(0, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h80,  0);
        vt[13] = mk(0, 1, 32'h60,  0, 0, 0, 32'h0,  32'h0,  32'h60,  0);
        vt[14] = mk(0, 0, 32'h0,   1, 1, 0, 32'h64, 32'hA0, 32'hA0,  0);
        vt[15] = mk(0, 1, 32'h60,  0, 0, 0, 32'h0,  32'h0,  32'h60,  1);
        vt[16] = mk(0, 1, 32'h20,  0, 0, 0, 32'h0,  32'h0,  32'h20,  0);
        vt[17] = mk(1, 0, 32'h0,   0, 0, 0, 32'h0,  32'h0,  32'h20,  0);

        // Reset state
        #3;
        chk("reset_pc", inst_mem_read_addr, 32'h0);
        chk("reset_take", {31'b0, IF_take}, 32'h0);
        do_reset();

        for (int k = 0; k < 18; k++) begin
            drive(vt[k].stall, vt[k].idb, vt[k].idt, vt[k].exb, vt[k].exz,
                  vt[k].expt, vt[k].expc, vt[k].ext);
            step();
            $display("vec %0d: pc=0x%08h take=%0d", k, inst_mem_read_addr, IF_take);
            chk($sformatf("vec%0d_pc", k), inst_mem_read_addr, vt[k].exp_pc);
            chk($sformatf("vec%0d_take", k), {31'b0, IF_take}, {31'b0, vt[k].exp_take});
        end

        // PC wrap-around
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        chk("wrap_setup", inst_mem_read_addr, 32'hFFFF_FFFC);
        idle();
        step();
        $display("wrap: pc=0x%08h", inst_mem_read_addr);
        chk("wrap_pc", inst_mem_read_addr, 32'h0);

        // Asynchronous reset mid-run at PC 0x40 with a redirect in flight
        do_reset();
        for (int k = 0; k < 16; k++) step();
        chk("pre_reset_pc", inst_mem_read_addr, 32'h40);
        drive(1'b0, 1'b1, 32'h200, 1'b1, 1'b1, 1'b0, 32'h44, 32'h300);
        #2;
        reset = 1'b1;
        #1;
        $display("async reset: pc=0x%08h take=%0d", inst_mem_read_addr, IF_take);
        chk("async_reset_pc", inst_mem_read_addr, 32'h0);
        chk("async_reset_take", {31'b0, IF_take}, 32'h0);
        idle();
        step();
        reset = 1'b0;
        m_reset();
        #1;
        chk("post_reset_pc0", inst_mem_read_addr, 32'h0);
        step();
        chk("post_reset_pc4", inst_mem_read_addr, 32'h4);
        step();
        chk("post_reset_pc8", inst_mem_read_addr, 32'h8);
        step();
        chk("post_reset_pcC", inst_mem_read_addr, 32'hC);

        // Random traffic against the reference model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom % 4) == 0, ($urandom % 8) == 0,
                  32'($urandom_range(0, 255)) << 2,
                  ($urandom % 3) == 0, 1'($urandom % 2), 1'($urandom % 2),
                  (32'($urandom_range(0, 47)) << 2) + 32'd4,
                  32'($urandom_range(0, 255)) << 2);
            m_step();
            step();
            if (k % 100 == 0)
                $display("rand %0d: pc=0x%08h take=%0d", k, inst_mem_read_addr, IF_take);
            chk($sformatf("rand%0d_pc", k), inst_mem_read_addr, m_pc);
            chk($sformatf("rand%0d_take", k), {31'b0, IF_take}, {31'b0, m_take(m_pc)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the program counter and drives the instruction-memory read address. It predicts conditional branches with a small direct-mapped branch history table plus branch target buffer, and exports the prediction as `IF_take`. It redirects the PC on ID-stage jumps and on EX-stage branch mispredictions.

## Interface
- `BHT_IDX_W`, default 4: log2 of the predictor entry count (16 entries).
- `RESET_PC`, default 32'h0: PC value after reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `EX_stall` in 1: hold the PC this cycle.
- `ID_branch` in 1: unconditional jump decoded in ID.
- `ID_jump_target` in 32: jump destination.
- `EX_branch` in 1: conditional branch resolving in EX.
- `EX_zero` in 1: actual outcome; 1 = taken.
- `EX_pred_take` in 1: the `IF_take` value carried down the pipeline with this branch.
- `EX_pc` in 32: branch address + 4, as carried in the pipeline PC field.
- `EX_branch_target` in 32: resolved taken-target.
- `inst_mem_read_addr` out 32: current PC.
- `IF_take` out 1: prediction for the instruction at the current PC.

## Operation
- Predictor has 2^BHT_IDX_W entries. Each entry holds:
  - `valid`
  - `tag` = pc[31:BHT_IDX_W+2]
  - `target` (32 bits)
  - `ctr` (2-bit saturating counter)
- Lookup index is pc[BHT_IDX_W+1:2].
- `IF_take` = valid && tag match && ctr[1]. It is combinational from the PC and predictor state.
- `mispredict` = EX_branch && (EX_zero != EX_pred_take).
- Next-PC selection, highest priority first:
  1. mispredict: PC <= EX_zero ? EX_branch_target : EX_pc.
  2. EX_stall: PC holds.
  3. ID_branch: PC <= ID_jump_target.
  4. IF_take: PC <= target of the hit entry.
  5. Otherwise: PC <= PC + 4, modulo 2^32 (wraps from FFFF_FFFC to 0).
- Predictor update happens when update_en = EX_branch && !EX_stall.
  - Entry index and tag come from EX_pc - 4.
  - Taken: ctr saturates up at 11; valid <= 1; tag and target written.
  - Not taken: ctr saturates down at 00; valid, tag and target are unchanged.
  - A not-taken update to an invalid or tag-mismatched entry changes only ctr.
- Same-cycle lookup and update of one entry: the lookup sees pre-update state. The write lands at the clock edge.
- Predictor state changes only at updates; there is no other invalidation.

## Timing
- Reset, asynchronous:
  - PC = RESET_PC.
  - All valid = 0, so `IF_take` = 0.
  - All ctr = 01 (weakly not-taken).
- Reset asserted mid-operation discards any in-flight redirect or update.
- Redirect latency is one cycle: the target appears on `inst_mem_read_addr` the cycle after the redirect condition is sampled.
- Mispredict overrides a simultaneous EX_stall and ID_branch.
- Under mispredict with EX_stall high, no predictor update occurs.
- A stall of N cycles holds the PC for N cycles. `IF_take` stays stable unless an update changes the entry being looked up.
- No handshake with instruction memory: the read address is valid every cycle after reset.

## Structure
- Shared package `fetch_pkg`:
  - Counter encodings SNT=00, WNT=01, WT=10, ST=11.
  - `PC_STEP` = 4.
  - Entry struct `{valid, tag, target, ctr}`.
- Sub-module `branch_predictor`:
  - Holds the entry array, lookup port and update port.
  - Lookup is combinational; update is registered.
- Top level `if_fetch_stage` contains the PC register and the next-PC priority mux.

## Test plan
- Reset mid-run with PC = 0x40: PC = 0 immediately; `IF_take` = 0. After release, PC reads 0, 4, 8, 0xC on successive cycles.
- ID_branch with target 0x100 at PC = 0x10: next PC = 0x100. With EX_stall also high, PC holds 0x10.
- Branch at 0x20 (EX_pc = 0x24, target 0x80), taken twice with EX_pred_take = 0:
  - Both times PC <= 0x80.
  - ctr goes 01 → 10 → 11.
  - The next fetch of 0x20 gives `IF_take` = 1 and next PC = 0x80.
- Predicted-taken branch resolves not taken (EX_zero = 0, EX_pred_take = 1, EX_pc = 0x24): PC <= 0x24; ctr 11 → 10.
- Mispredict, EX_stall and ID_branch in the same cycle: mispredict target wins and the predictor is unchanged. Aliasing branch at 0x60 (same index, different tag): `IF_take` = 0 until its own taken update.
- PC = 0xFFFF_FFFC with no events: next PC = 0.
